// File: rtl/thermal_upscaler.sv
// Thermal-camera upscaler: maps each screen pixel to its thermal cell, fetches the
// sample, auto-ranges it per frame and colours it; syncs are delayed to stay aligned.
module thermal_upscaler #(
    parameter int P_SCALE = 20,
    parameter int P_COLS  = 32,
    parameter int P_ROWS  = 24
) (
    input  logic               i_clk_pixel,
    input  logic               i_rst,
    input  logic               i_hsync,
    input  logic               i_vsync,
    input  logic               i_de,
    input  logic signed [15:0] i_x_pos,
    input  logic signed [15:0] i_y_pos,
    output logic [9:0]         o_rd_addr,
    input  logic [15:0]        i_rd_data,
    output logic               o_hsync,
    output logic               o_vsync,
    output logic               o_de,
    output logic [23:0]        o_data
);
    localparam int SW = (P_SCALE > 1) ? $clog2(P_SCALE) : 1;
    localparam logic [SW-1:0]      L_SUB_LAST = SW'(P_SCALE - 1);
    localparam logic [4:0]         L_COL_LAST = 5'(P_COLS - 1);
    localparam logic [4:0]         L_ROW_LAST = 5'(P_ROWS - 1);
    localparam logic signed [15:0] L_X_LIM    = 16'(P_COLS * P_SCALE);
    localparam logic signed [15:0] L_Y_LIM    = 16'(P_ROWS * P_SCALE);

    logic          r_de_prev, r_vs_prev;
    logic          r_col_run, r_row_run;
    logic [SW-1:0] r_sub_x, r_sub_y;
    logic [4:0]    r_cell_x, r_cell_y;

    logic          w_de_rise, w_de_fall, w_row_clr, w_area, w_vs_rise;
    logic [SW-1:0] w_sub_x;
    logic [4:0]    w_cell_x, w_cell_y;

    logic [9:0]    r_rd_addr;
    logic [2:0]    r_sync1, r_sync2, r_sync3, r_sync4;
    logic          r_area1, r_area2, r_area3;
    logic [7:0]    r_idx;
    logic [23:0]   r_data;

    logic [15:0]   r_min, r_max, r_act_min;
    logic [3:0]    r_act_shift;

    logic [15:0]   w_range, w_diff, w_scaled;
    logic [4:0]    w_len;
    logic [3:0]    w_shift;
    logic [7:0]    w_idx;
    logic [7:0]    w_red, w_grn, w_blu;

    assign w_de_rise = i_de & ~r_de_prev;
    assign w_de_fall = ~i_de & r_de_prev;
    assign w_row_clr = w_de_rise && (i_y_pos == 16'sd0);
    assign w_vs_rise = i_vsync & ~r_vs_prev;
    assign w_area    = i_de && (i_x_pos >= 16'sd0) && (i_x_pos < L_X_LIM)
                            && (i_y_pos >= 16'sd0) && (i_y_pos < L_Y_LIM);

    // Position of the pixel being sampled now; a line start overrides the stored count.
    always_comb begin
        w_sub_x  = w_de_rise ? '0 : r_sub_x;
        w_cell_x = w_de_rise ? '0 : r_cell_x;
        w_cell_y = w_row_clr ? '0 : r_cell_y;
    end

    // Run flags keep a line or frame interrupted by reset from counting until realigned.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            r_de_prev <= i_de;
            r_col_run <= 1'b0;
            r_row_run <= 1'b0;
            r_sub_x   <= '0;
            r_cell_x  <= '0;
            r_sub_y   <= '0;
            r_cell_y  <= '0;
        end else begin
            r_de_prev <= i_de;
            if (w_de_rise) begin
                r_col_run <= 1'b1;
            end
            if (i_de && (w_de_rise || r_col_run)) begin
                if (w_sub_x == L_SUB_LAST) begin
                    r_sub_x  <= '0;
                    r_cell_x <= (w_cell_x != L_COL_LAST) ? w_cell_x + 5'd1 : w_cell_x;
                end else begin
                    r_sub_x  <= w_sub_x + 1'b1;
                    r_cell_x <= w_cell_x;
                end
            end
            if (w_row_clr) begin
                r_row_run <= 1'b1;
                r_sub_y   <= '0;
                r_cell_y  <= '0;
            end else if (w_de_fall && r_row_run) begin
                if (r_sub_y == L_SUB_LAST) begin
                    r_sub_y <= '0;
                    if (r_cell_y != L_ROW_LAST) begin
                        r_cell_y <= r_cell_y + 5'd1;
                    end
                end else begin
                    r_sub_y <= r_sub_y + 1'b1;
                end
            end
        end
    end

    // Range bit length drives the shift that fits the frame span into 8 bits.
    always_comb begin
        w_range = r_max - r_min;
        w_len   = 5'd0;
        for (int i = 0; i < 16; i++) begin
            if (w_range[i]) begin
                w_len = 5'(i + 1);
            end
        end
        w_shift  = (w_len > 5'd8) ? 4'(w_len - 5'd8) : 4'd0;
        w_diff   = i_rd_data - r_act_min;
        w_scaled = w_diff >> r_act_shift;
        if (i_rd_data < r_act_min) begin
            w_idx = 8'd0;
        end else if (w_scaled > 16'd255) begin
            w_idx = 8'hFF;
        end else begin
            w_idx = w_scaled[7:0];
        end
    end

    always_comb begin
        w_red = r_idx[7] ? 8'hFF : {r_idx[6:0], 1'b0};
        w_grn = r_idx[7] ? {r_idx[6:0], 1'b1} : 8'h00;
        w_blu = r_idx[7] ? 8'h00 : (r_idx[6] ? {~r_idx[5:0], 2'b00} : {r_idx[5:0], 2'b00});
    end

    // Stages: 1 address, 2 RAM read, 3 colour index, 4 palette.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            r_rd_addr <= '0;
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_sync3   <= '0;
            r_sync4   <= '0;
            r_area1   <= 1'b0;
            r_area2   <= 1'b0;
            r_area3   <= 1'b0;
            r_idx     <= '0;
            r_data    <= '0;
        end else begin
            r_rd_addr <= {w_cell_y, w_cell_x};
            r_sync1   <= {i_hsync, i_vsync, i_de};
            r_area1   <= w_area;
            r_sync2   <= r_sync1;
            r_area2   <= r_area1;
            r_sync3   <= r_sync2;
            r_area3   <= r_area2;
            r_idx     <= r_area2 ? w_idx : 8'd0;
            r_sync4   <= r_sync3;
            r_data    <= r_area3 ? {w_blu, w_grn, w_red} : 24'd0;
        end
    end

    // A sample landing on the vsync edge seeds the new frame's trackers.
    always_ff @(posedge i_clk_pixel) begin
        if (i_rst) begin
            r_vs_prev   <= i_vsync;
            r_min       <= 16'hFFFF;
            r_max       <= 16'h0000;
            r_act_min   <= 16'h0000;
            r_act_shift <= 4'd8;
        end else begin
            r_vs_prev <= i_vsync;
            if (w_vs_rise) begin
                if (r_min <= r_max) begin
                    r_act_min   <= r_min;
                    r_act_shift <= w_shift;
                end
                r_min <= r_area2 ? i_rd_data : 16'hFFFF;
                r_max <= r_area2 ? i_rd_data : 16'h0000;
            end else if (r_area2) begin
                if (i_rd_data < r_min) begin
                    r_min <= i_rd_data;
                end
                if (i_rd_data > r_max) begin
                    r_max <= i_rd_data;
                end
            end
        end
    end

    assign o_rd_addr = r_rd_addr;
    assign o_hsync   = r_sync4[2];
    assign o_vsync   = r_sync4[1];
    assign o_de      = r_sync4[0];
    assign o_data    = r_data;

endmodule

// File: tb/tb_thermal_upscaler.sv
// Bench for thermal_upscaler: lockstep stimulus with an edge-accurate model whose
// expected outputs go through a scoreboard queue; addresses are checked each cycle.
module tb_thermal_upscaler;
    localparam int SC = 20;
    localparam int NC = 32;
    localparam int NR = 24;
    localparam int W  = NC * SC;
    localparam int H  = NR * SC;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst, hs, vs, de;
    logic signed [15:0] xp, yp;
    logic [9:0]         rd_addr;
    logic [15:0]        rd_data;
    logic               ohs, ovs, ode;
    logic [23:0]        odata;

    logic [15:0] mem [0:1023];
    always @(posedge clk) rd_data <= mem[rd_addr];

    thermal_upscaler #(.P_SCALE(SC), .P_COLS(NC), .P_ROWS(NR)) dut (
        .i_clk_pixel(clk),
        .i_rst      (rst),
        .i_hsync    (hs),
        .i_vsync    (vs),
        .i_de       (de),
        .i_x_pos    (xp),
        .i_y_pos    (yp),
        .o_rd_addr  (rd_addr),
        .i_rd_data  (rd_data),
        .o_hsync    (ohs),
        .o_vsync    (ovs),
        .o_de       (ode),
        .o_data     (odata)
    );

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [23:0] data;
    } exp_t;

    typedef struct {
        logic       hs;
        logic       vs;
        logic       de;
        logic       area;
        logic       chk;
        logic [9:0] addr;
    } pix_t;

    exp_t sbq[$];
    pix_t h1, h2;
    int   n_total = 0;
    int   n_bad   = 0;

    int   act_min, act_shift, m_min, m_max, xcnt, ycnt;
    logic col_ok, row_ok, m_de_prev, m_vs_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [23:0] pal(input int idx);
        int r, g, b;
        r = (2 * idx > 255) ? 255 : 2 * idx;
        g = (idx < 128) ? 0 : 2 * (idx - 128) + 1;
        if (idx < 64)       b = 4 * idx;
        else if (idx < 128) b = 4 * (127 - idx);
        else                b = 0;
        return {b[7:0], g[7:0], r[7:0]};
    endfunction

    // One pixel clock: check what is due, drive the new inputs, advance the model by one edge.
    task automatic tick(input logic r, input logic h, input logic v, input logic d,
                        input int x, input int y);
        exp_t e;
        pix_t cur;
        int   smp, idx, cx, cy, rng, len;
        logic rise, fall;
        @(negedge clk);
        if (sbq.size() >= 2) begin
            e = sbq.pop_front();
            chk("sync", {29'd0, ohs, ovs, ode}, {29'd0, e.hs, e.vs, e.de});
            chk("rgb", {8'd0, odata}, {8'd0, e.data});
        end
        if (h1.chk) chk("addr", {22'd0, rd_addr}, {22'd0, h1.addr});
        rst = r; hs = h; vs = v; de = d; xp = 16'(x); yp = 16'(y);
        cur = '{default: '0};
        if (r) begin
            sbq.delete();
            sbq.push_back('0);
            sbq.push_back('0);
            h1 = '{default: '0};
            act_min = 0; act_shift = 8; m_min = 65535; m_max = 0;
            col_ok = 1'b0; row_ok = 1'b0; xcnt = 0; ycnt = 0;
        end else begin
            rise = d && !m_de_prev;
            fall = !d && m_de_prev;
            if (rise) begin col_ok = 1'b1; xcnt = 0; end
            if (rise && y == 0) begin row_ok = 1'b1; ycnt = 0; end
            cx = 0;
            cy = 0;
            if (col_ok) begin cx = xcnt / SC; if (cx > NC - 1) cx = NC - 1; end
            if (row_ok) begin cy = ycnt / SC; if (cy > NR - 1) cy = NR - 1; end
            if (d && col_ok) xcnt++;
            if (fall && row_ok) ycnt++;
            cur.hs = h; cur.vs = v; cur.de = d; cur.chk = 1'b1;
            cur.area = d && x >= 0 && x < W && y >= 0 && y < H;
            cur.addr = 10'(cy * 32 + cx);
            smp = int'(mem[h2.addr]);
            e = '0;
            e.hs = h2.hs; e.vs = h2.vs; e.de = h2.de;
            if (h2.area) begin
                if (smp < act_min) idx = 0;
                else begin
                    idx = (smp - act_min) >> act_shift;
                    if (idx > 255) idx = 255;
                end
                e.data = pal(idx);
            end
            sbq.push_back(e);
            if (v && !m_vs_prev) begin
                if (m_min <= m_max) begin
                    rng = m_max - m_min;
                    len = $clog2(rng + 1);
                    act_min = m_min;
                    act_shift = (len > 8) ? len - 8 : 0;
                end
                m_min = 65535; m_max = 0;
            end
            if (h2.area) begin
                if (smp < m_min) m_min = smp;
                if (smp > m_max) m_max = smp;
            end
        end
        m_de_prev = d;
        m_vs_prev = v;
        h2 = h1;
        h1 = cur;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, -10, -10);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b1, 1'b0, -10, -10);
        idle(2);
    endtask

    task automatic line(input int y, input int n, input int rst_x);
        tick(1'b0, 1'b1, 1'b0, 1'b0, -10, y);
        tick(1'b0, 1'b1, 1'b0, 1'b0, -10, y);
        for (int x = 0; x < n; x++) tick(x == rst_x, 1'b0, 1'b0, 1'b1, x, y);
        idle(3);
    endtask

    initial begin
        rst = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; xp = '0; yp = '0;
        h1 = '{default: '0};
        h2 = '{default: '0};
        act_min = 0; act_shift = 8; m_min = 65535; m_max = 0;
        xcnt = 0; ycnt = 0; col_ok = 1'b0; row_ok = 1'b0;
        m_de_prev = 1'b0; m_vs_prev = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'(1100 + (i % 50) * 3);

        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        idle(6);

        // random sync patterns, all outside the thermal area
        for (int i = 0; i < 150; i++)
            tick(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), -5, -5);
        idle(6);

        // auto-range: span 1000..1255 then a mid sample
        mem[0] = 16'd1000; mem[1] = 16'd1255;
        vsync_pulse();
        line(0, 40, -1);
        vsync_pulse();
        mem[2] = 16'd1128;
        line(0, 60, -1);

        // wide range 0..4095
        mem[0] = 16'd0; mem[1] = 16'd4095;
        vsync_pulse();
        line(0, 40, -1);
        vsync_pulse();
        mem[2] = 16'd1024;
        line(0, 60, -1);

        // post-reset defaults, then a sample below act_min
        for (int i = 0; i < 2; i++) tick(1'b1, 1'b0, 1'b0, 1'b0, -10, -10);
        idle(2);
        mem[0] = 16'h4000;
        line(0, 20, -1);
        mem[0] = 16'd500; mem[1] = 16'd600;
        vsync_pulse();
        line(0, 40, -1);
        vsync_pulse();
        mem[0] = 16'd100;
        line(0, 40, -1);

        // full 640x480 addressing with saturation beyond the area
        for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom_range(0, 65535));
        vsync_pulse();
        line(0, W, -1);
        for (int y = 1; y < H - 1; y++) line(y, 2, -1);
        line(H - 1, 701, -1);
        line(H, 2, -1);

        // mid-frame reset at x=300, y=200
        vsync_pulse();
        line(0, 2, -1);
        line(200, W, 300);
        for (int y = 201; y < 204; y++) line(y, 40, -1);
        vsync_pulse();
        line(0, 40, -1);
        line(1, 2, -1);
        idle(8);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/thermal_upscaler.md
THERMAL_UPSCALER -- requirements
Module: thermal_upscaler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset. The clock port is i_clk_pixel and the reset port is i_rst.
REQ-002 Parameters (name, default, meaning), one per line:
- P_SCALE, 20, screen pixels per thermal cell along each axis.
- P_COLS, 32, thermal columns.
- P_ROWS, 24, thermal rows.
REQ-003 Ports (name, direction, width, meaning), one per line:
- i_clk_pixel, in, 1, pixel clock.
- i_rst, in, 1, sync reset, active high.
- i_hsync, in, 1, horizontal sync from the timing generator.
- i_vsync, in, 1, vertical sync from the timing generator.
- i_de, in, 1, active video.
- i_x_pos, in, 16 signed, current pixel column.
- i_y_pos, in, 16 signed, current pixel row.
- o_rd_addr, out, 10, thermal RAM address, {cell_y[4:0], cell_x[4:0]}.
- i_rd_data, in, 16 unsigned, thermal sample; valid exactly 1 cycle after o_rd_addr.
- o_hsync, out, 1, delayed hsync.
- o_vsync, out, 1, delayed vsync.
- o_de, out, 1, delayed de.
- o_data, out, 3x8, RGB to the DVI encoder; [0]=R, [1]=G, [2]=B.

Function
REQ-004 o_hsync, o_vsync and o_de SHALL equal i_hsync, i_vsync and i_de delayed by exactly 4 clock cycles.
REQ-005 o_data SHALL be aligned with the delayed o_de: the pixel sampled at edge N appears after edge N+4.
REQ-006 Cell counters SHALL be incremental, with no divider:
- sub_x (0..P_SCALE-1) and cell_x (0..P_COLS-1) advance once per i_de cycle.
- sub_x wraps to 0 and cell_x increments when sub_x reaches P_SCALE-1.
- On each i_de rising edge, sub_x and cell_x are cleared to 0.
REQ-007 Row counters sub_y and cell_y SHALL advance on each i_de falling edge, with the same wrap rule as the column counters.
REQ-008 On an i_de rising edge with i_y_pos==0, sub_y and cell_y SHALL be cleared to 0.
REQ-009 A pixel is in-area iff i_de=1, 0<=i_x_pos<P_COLS*P_SCALE and 0<=i_y_pos<P_ROWS*P_SCALE. Out-of-area pixels SHALL produce o_data = {0,0,0}.
REQ-010 cell_x SHALL saturate at P_COLS-1 and cell_y SHALL saturate at P_ROWS-1; neither ever wraps to 0 inside a line or frame.
REQ-011 o_rd_addr SHALL be registered and driven 1 cycle after the input sample (pipeline stage 1).
REQ-012 Running statistics SHALL track the min and max of i_rd_data over in-area samples of the current frame. The trackers are reset to 16'hFFFF (min) and 16'h0000 (max).
REQ-013 On an i_vsync rising edge the block SHALL, in the same cycle:
- latch the trackers into act_min and act_shift;
- reset the trackers to their initial values.
An in-area sample arriving in that same cycle belongs to the new frame.
REQ-014 act_shift SHALL be max(0, L-8), where L is the bit length of (max-min). A range of 0 gives shift 0.
REQ-015 If no in-area sample was seen during a frame (min>max), the latch SHALL keep its previous act_min and act_shift.
REQ-016 The colour index SHALL be computed as follows:
- If i_rd_data < act_min, idx = 0.
- Otherwise idx = (i_rd_data - act_min) >> act_shift, saturated to 255.
- This computation is registered (stage 3).
REQ-017 The palette SHALL be registered (stage 4) and defined as:
- R = min(255, 2*idx).
- G = 0 for idx<128; otherwise 2*(idx-128)+1.
- B = 4*idx for idx<64; 4*(127-idx) for idx 64..127; 0 for idx>=128.

Reset
REQ-018 While i_rst=1, the block SHALL force the following:
- all outputs, o_rd_addr and the delay pipeline to 0;
- the counters to 0;
- the trackers to FFFF/0000;
- act_min=0 and act_shift=8.
REQ-019 Reset SHALL take effect at the first clock edge with i_rst=1. The first valid output appears 4 cycles after the first input sampled post-reset.
REQ-020 Reset asserted mid-line SHALL abandon the line: counters resume on the next i_de rising edge, and row alignment resumes on the next i_y_pos==0 line.

Verification
REQ-021 Sync latency: toggle i_hsync, i_vsync and i_de with random patterns -> each output is an exact 4-cycle delayed copy.
REQ-022 Addressing over 640x480:
- x=0..19 -> o_rd_addr cell_x=0; x=20 -> cell_x=1.
- y=479, x=639 -> o_rd_addr=10'h2FF (cell 23,31).
- x=700 in-area-false -> o_data=0.
REQ-023 Auto-range:
- Frame 1 samples span 1000..1255, then an i_vsync rise -> act_min=1000, act_shift=0.
- In frame 2, sample 1128 -> idx=128 -> RGB=(255,1,0).
REQ-024 Wide range: samples span 0..4095 -> act_shift=4. Sample 4095 -> idx=255 -> RGB=(255,255,0). Sample 1024 -> idx=64 -> RGB=(128,0,252).
REQ-025 Post-reset defaults: act_min=0, act_shift=8. Sample 16'h4000 -> idx=64 -> RGB=(128,0,252). Sample below act_min is impossible; with act_min=500, sample 100 -> RGB=(0,0,0).
REQ-026 Mid-frame reset: assert i_rst for 1 cycle at x=300,y=200 ->
- outputs are 0 the next cycle;
- counters restart at the next line;
- act_shift=8 until the next i_vsync rise.
